// File: rtl/axis_chk_pkg.sv
// Shared types and constants for the multi-lane AXI-Stream packet checker.
package axis_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } lane_state_e;

    localparam int ERR_LEN  = 0;
    localparam int ERR_KEEP = 1;
    localparam int ERR_OVR  = 2;

    // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1 (bits 15, 13, 12, 10).
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/axis_chk_lane.sv
// One receive lane: packet FSM, beat/packet counters, length/keep/overrun
// checks and the free-running throttle LFSR.
module axis_chk_lane
    import axis_chk_pkg::*;
#(
    parameter int          DW       = 512,
    parameter int          THROTTLE = 0,
    parameter logic [15:0] SEED     = 16'd1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start_i,
    input  logic [15:0]     packet_count_i,
    input  logic [15:0]     packet_size_i,
    input  logic [DW/8-1:0] tkeep_i,
    input  logic            tlast_i,
    input  logic            tvalid_i,
    output logic            tready_o,
    output logic            done_o,
    output logic [2:0]      error_o,
    output logic [15:0]     rx_packets_o
);

    localparam int BPB   = DW / 8;
    localparam int SHIFT = $clog2(BPB);

    lane_state_e     state_q, state_d;
    logic [15:0]     lfsr_q;
    logic [15:0]     beat_cnt_q;
    logic [15:0]     rx_q;
    logic [15:0]     count_q;
    logic [16:0]     last_idx_q;
    logic [BPB-1:0]  keep_last_q;
    logic [2:0]      err_q;

    logic [16:0]     beats_exp;
    logic [15:0]     rem;
    logic [BPB-1:0]  keep_last_d;
    logic            hs;
    logic            run_last;
    logic            final_pkt;
    logic [15:0]     rx_inc;

    always_comb begin
        beats_exp = ({1'b0, packet_size_i} + 17'(BPB - 1)) >> SHIFT;
        rem       = packet_size_i & 16'(BPB - 1);
        for (int k = 0; k < BPB; k++) begin
            keep_last_d[k] = (rem == 16'd0) || (16'(k) < rem);
        end
    end

    assign hs        = tvalid_i & tready_o;
    assign run_last  = hs && tlast_i && (state_q == RUN);
    assign rx_inc    = rx_q + 16'd1;
    assign final_pkt = run_last && (rx_inc == count_q);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        if (start_i) begin
            state_d = (packet_count_i == 16'd0 || packet_size_i == 16'd0) ? DONE : RUN;
        end else if (final_pkt) begin
            state_d = DONE;
        end
    end

    always_comb begin
        tready_o = 1'b0;
        done_o   = 1'b0;
        case (state_q)
            RUN:     tready_o = (THROTTLE != 0) ? (lfsr_q[0] | lfsr_q[1]) : 1'b1;
            DONE: begin
                tready_o = 1'b1;
                done_o   = 1'b1;
            end
            default: ;
        endcase
    end

    // start takes priority over any handshake in the same cycle, discarding that beat.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            lfsr_q      <= SEED;
            beat_cnt_q  <= 16'd0;
            rx_q        <= 16'd0;
            count_q     <= 16'd0;
            last_idx_q  <= 17'd0;
            keep_last_q <= '0;
            err_q       <= 3'd0;
        end else begin
            lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
            if (start_i) begin
                beat_cnt_q  <= 16'd0;
                rx_q        <= 16'd0;
                err_q       <= 3'd0;
                count_q     <= packet_count_i;
                last_idx_q  <= beats_exp - 17'd1;
                keep_last_q <= keep_last_d;
            end else if (hs && state_q == DONE) begin
                err_q[ERR_OVR] <= 1'b1;
            end else if (hs && state_q == RUN) begin
                if (tlast_i) begin
                    beat_cnt_q <= 16'd0;
                    rx_q       <= rx_inc;
                    if ({1'b0, beat_cnt_q} != last_idx_q) err_q[ERR_LEN] <= 1'b1;
                    if (tkeep_i != keep_last_q)           err_q[ERR_KEEP] <= 1'b1;
                end else begin
                    if (beat_cnt_q != 16'hFFFF) beat_cnt_q <= beat_cnt_q + 16'd1;
                    if ({1'b0, beat_cnt_q} >= last_idx_q) err_q[ERR_LEN] <= 1'b1;
                    if (tkeep_i != '1)                     err_q[ERR_KEEP] <= 1'b1;
                end
            end
        end
    end

    assign error_o      = err_q;
    assign rx_packets_o = rx_q;

endmodule

// File: rtl/axis_packet_checker.sv
// Multi-lane AXI-Stream packet checker: slices the lane buses and fans out
// the shared start/configuration to one checker per lane.
module axis_packet_checker #(
    parameter int DW       = 512,
    parameter int NCH      = 2,
    parameter int THROTTLE = 0
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [15:0]           packet_count,
    input  logic [15:0]           packet_size,
    input  logic [NCH*DW-1:0]     s_axis_tdata,
    input  logic [NCH*DW/8-1:0]   s_axis_tkeep,
    input  logic [NCH-1:0]        s_axis_tlast,
    input  logic [NCH-1:0]        s_axis_tvalid,
    output logic [NCH-1:0]        s_axis_tready,
    output logic [NCH-1:0]        done,
    output logic [NCH*3-1:0]      error,
    output logic [NCH*16-1:0]     rx_packets
);

    localparam int BPB = DW / 8;

    // Payload content is never checked.
    logic unused_tdata;
    assign unused_tdata = ^s_axis_tdata;

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        axis_chk_lane #(
            .DW       (DW),
            .THROTTLE (THROTTLE),
            .SEED     (16'(i + 1))
        ) u_lane (
            .clk            (clk),
            .resetn         (resetn),
            .start_i        (start),
            .packet_count_i (packet_count),
            .packet_size_i  (packet_size),
            .tkeep_i        (s_axis_tkeep[i*BPB +: BPB]),
            .tlast_i        (s_axis_tlast[i]),
            .tvalid_i       (s_axis_tvalid[i]),
            .tready_o       (s_axis_tready[i]),
            .done_o         (done[i]),
            .error_o        (error[i*3 +: 3]),
            .rx_packets_o   (rx_packets[i*16 +: 16])
        );
    end

endmodule

// File: tb/tb_axis_packet_checker.sv
// Randomized self-checking bench for axis_packet_checker against a
// packet-level reference model; a second throttled instance checks TREADY gating.
module tb_axis_packet_checker;

    localparam int DW  = 64;
    localparam int NCH = 2;
    localparam int BPB = DW / 8;
    localparam int KW  = NCH * BPB;

    typedef struct packed {
        logic [7:0] keep;
        logic       last;
    } beat_t;

    logic clk = 1'b0;
    logic resetn;

    logic              start;
    logic [15:0]       packet_count, packet_size;
    logic [NCH*DW-1:0] tdata;
    logic [KW-1:0]     tkeep;
    logic [NCH-1:0]    tlast, tvalid, tready, done;
    logic [NCH*3-1:0]  error;
    logic [NCH*16-1:0] rx_packets;

    logic              t_start;
    logic [15:0]       t_packet_count, t_packet_size;
    logic [NCH*DW-1:0] t_tdata;
    logic [KW-1:0]     t_tkeep;
    logic [NCH-1:0]    t_tlast, t_tvalid, t_tready, t_done;
    logic [NCH*3-1:0]  t_error;
    logic [NCH*16-1:0] t_rx_packets;

    axis_packet_checker #(.DW(DW), .NCH(NCH), .THROTTLE(0)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .packet_count(packet_count), .packet_size(packet_size),
        .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tlast(tlast),
        .s_axis_tvalid(tvalid), .s_axis_tready(tready),
        .done(done), .error(error), .rx_packets(rx_packets)
    );

    axis_packet_checker #(.DW(DW), .NCH(NCH), .THROTTLE(1)) dut_thr (
        .clk(clk), .resetn(resetn), .start(t_start),
        .packet_count(t_packet_count), .packet_size(t_packet_size),
        .s_axis_tdata(t_tdata), .s_axis_tkeep(t_tkeep), .s_axis_tlast(t_tlast),
        .s_axis_tvalid(t_tvalid), .s_axis_tready(t_tready),
        .done(t_done), .error(t_error), .rx_packets(t_rx_packets)
    );

    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model state, per lane.
    bit          m_armed[NCH];
    bit          m_done[NCH];
    logic [15:0] m_rx[NCH];
    logic [2:0]  m_err[NCH];
    int          m_idx[NCH];
    int          m_size;
    int          m_count;
    logic [15:0] m_lfsr[NCH];

    beat_t lane_q[NCH][$];

    // Throttle sequence: polynomial x^16+x^14+x^13+x^11+1, one step per clock.
    always @(posedge clk or negedge resetn) begin
        for (int l = 0; l < NCH; l++) begin
            if (!resetn) m_lfsr[l] <= 16'(l + 1);
            else         m_lfsr[l] <= {m_lfsr[l][14:0],
                                       m_lfsr[l][15] ^ m_lfsr[l][13] ^ m_lfsr[l][12] ^ m_lfsr[l][10]};
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int beats_for(int size);
        return (size + BPB - 1) / BPB;
    endfunction

    function automatic logic [7:0] keep_for_last(int size);
        int r = size % BPB;
        if (r == 0) return 8'hFF;
        return 8'((1 << r) - 1);
    endfunction

    task automatic model_reset();
        for (int l = 0; l < NCH; l++) begin
            m_armed[l] = 0; m_done[l] = 0; m_rx[l] = 16'd0; m_err[l] = 3'd0; m_idx[l] = 0;
        end
    endtask

    task automatic model_start();
        m_size  = int'(packet_size);
        m_count = int'(packet_count);
        for (int l = 0; l < NCH; l++) begin
            m_armed[l] = 1;
            m_rx[l]    = 16'd0;
            m_err[l]   = 3'd0;
            m_idx[l]   = 0;
            m_done[l]  = (m_count == 0) || (m_size == 0);
        end
    endtask

    task automatic model_beat(input int l, input logic [7:0] keep, input logic last);
        int last_idx;
        if (m_done[l]) begin
            m_err[l][2] = 1'b1;
            return;
        end
        last_idx = beats_for(m_size) - 1;
        if (last) begin
            if (m_idx[l] != last_idx)         m_err[l][0] = 1'b1;
            if (keep != keep_for_last(m_size)) m_err[l][1] = 1'b1;
            m_idx[l] = 0;
            m_rx[l]  = m_rx[l] + 16'd1;
            if (m_rx[l] == 16'(m_count)) m_done[l] = 1;
        end else begin
            if (m_idx[l] >= last_idx) m_err[l][0] = 1'b1;
            if (keep != 8'hFF)        m_err[l][1] = 1'b1;
            if (m_idx[l] < 65535) m_idx[l]++;
        end
    endtask

    task automatic check_outputs();
        logic [NCH-1:0]    e_rdy, e_done;
        logic [NCH*3-1:0]  e_err;
        logic [NCH*16-1:0] e_rx;
        for (int l = 0; l < NCH; l++) begin
            e_rdy[l]          = m_armed[l];
            e_done[l]         = m_done[l];
            e_err[l*3 +: 3]   = m_err[l];
            e_rx[l*16 +: 16]  = m_rx[l];
        end
        check("tready", 64'(tready), 64'(e_rdy));
        check("done", 64'(done), 64'(e_done));
        check("error", 64'(error), 64'(e_err));
        check("rx_packets", 64'(rx_packets), 64'(e_rx));
    endtask

    // One clock: DUT and model both consume the inputs driven before the edge.
    task automatic step();
        logic [NCH-1:0] rdy;
        for (int l = 0; l < NCH; l++) rdy[l] = m_armed[l];
        @(posedge clk);
        if (start) model_start();
        else begin
            for (int l = 0; l < NCH; l++) begin
                if (tvalid[l] && rdy[l]) model_beat(l, tkeep[l*BPB +: BPB], tlast[l]);
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_start(input int size, input int count, input logic [NCH-1:0] vmask);
        packet_size  = 16'(size);
        packet_count = 16'(count);
        start  = 1'b1;
        tvalid = vmask;
        tkeep  = '1;
        tlast  = '1;
        step();
        start  = 1'b0;
        tvalid = '0;
        packet_size  = 16'($urandom);
        packet_count = 16'($urandom);
    endtask

    // kind: 0 clean, 1 one beat short (long if single-beat), 2 random bad last keep,
    // 3 bad mid keep 0x7F, 4 last keep 0xFF, 5 one beat long
    task automatic add_packet(input int l, input int size, input int kind);
        int         n  = beats_for(size);
        logic [7:0] kl = keep_for_last(size);
        beat_t      b;
        if (kind == 1) n = (n > 1) ? n - 1 : n + 1;
        if (kind == 5) n = n + 1;
        for (int i = 0; i < n; i++) begin
            b.last = (i == n - 1);
            b.keep = b.last ? kl : 8'hFF;
            if (kind == 2 && b.last) b.keep = kl ^ (8'd1 << $urandom_range(7));
            if (kind == 3 && n > 1 && i == 0) b.keep = 8'h7F;
            if (kind == 3 && n == 1) b.keep = kl ^ 8'h80;
            if (kind == 4 && b.last) b.keep = (kl == 8'hFF) ? 8'h7F : 8'hFF;
            lane_q[l].push_back(b);
        end
    endtask

    task automatic run_queues(input int valid_pct, input int budget);
        int cyc = 0;
        while ((lane_q[0].size() > 0 || lane_q[1].size() > 0) && cyc < budget) begin
            logic [NCH-1:0] pres;
            pres  = '0;
            tdata = {$urandom, $urandom, $urandom, $urandom};
            for (int l = 0; l < NCH; l++) begin
                if (lane_q[l].size() > 0 && $urandom_range(99) < valid_pct) begin
                    pres[l]            = 1'b1;
                    tvalid[l]          = 1'b1;
                    tkeep[l*BPB +: BPB] = lane_q[l][0].keep;
                    tlast[l]           = lane_q[l][0].last;
                end else begin
                    tvalid[l]          = 1'b0;
                    tkeep[l*BPB +: BPB] = 8'($urandom);
                    tlast[l]           = 1'($urandom);
                end
            end
            for (int l = 0; l < NCH; l++) begin
                if (pres[l] && m_armed[l]) void'(lane_q[l].pop_front());
            end
            step();
            cyc++;
        end
        tvalid = '0;
        check("queue_drained", 64'(lane_q[0].size() + lane_q[1].size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi[NCH];
        int diff;
        int lfsr_bad;
        resetn = 1'b0;
        start = 1'b0; packet_count = '0; packet_size = '0;
        tdata = '0; tkeep = '0; tlast = '0; tvalid = '0;
        t_start = 1'b0; t_packet_count = '0; t_packet_size = '0;
        t_tdata = '0; t_tkeep = '0; t_tlast = '0; t_tvalid = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs();
        check("thr_reset_tready", 64'(t_tready), 64'd0);
        resetn = 1'b1;
        step();

        // Three clean packets on both lanes.
        do_start(20, 3, '0);
        for (int l = 0; l < NCH; l++) repeat (3) add_packet(l, 20, 0);
        run_queues(100, 200);
        check("A_done", 64'(done), 64'b11);
        check("A_rx", 64'(rx_packets), {32'd0, 16'd3, 16'd3});
        check("A_err", 64'(error), 64'd0);

        // Short packet on lane 0 only.
        do_start(20, 3, '0);
        add_packet(0, 20, 1);
        add_packet(1, 20, 0);
        run_queues(100, 100);
        check("B_err", 64'(error), 64'b000_001);
        check("B_rx", 64'(rx_packets), {32'd0, 16'd1, 16'd1});

        // Last keep 0xFF on lane 0, mid keep 0x7F on lane 1.
        do_start(20, 3, '0);
        add_packet(0, 20, 4);
        add_packet(1, 20, 3);
        run_queues(100, 100);
        check("C_err", 64'(error), 64'b010_010);

        // Overrun after done on lane 0.
        do_start(8, 1, '0);
        add_packet(0, 8, 0);
        add_packet(1, 8, 0);
        add_packet(0, 8, 0);
        run_queues(100, 100);
        check("D_done", 64'(done), 64'b11);
        check("D_err", 64'(error), 64'b000_100);
        check("D_tready", 64'(tready), 64'b11);
        check("D_rx", 64'(rx_packets), {32'd0, 16'd1, 16'd1});

        // Zero count / zero size go straight to done.
        do_start(20, 0, '0);
        check("E_done_cnt0", 64'(done), 64'b11);
        do_start(0, 5, '0);
        check("E_done_size0", 64'(done), 64'b11);
        add_packet(1, 8, 0);
        run_queues(100, 50);
        check("E_ovr", 64'(error), 64'b100_000);

        // start mid-packet clears a pending error; the beat under start is dropped.
        do_start(20, 3, '0);
        add_packet(0, 20, 3);
        lane_q[0].push_back('{keep: 8'hFF, last: 1'b0});
        lane_q[0].push_back('{keep: 8'hFF, last: 1'b0});
        run_queues(100, 50);
        check("F_err_before", 64'(error), 64'b000_010);
        do_start(20, 3, 2'b01);
        check("F_err_cleared", 64'(error), 64'd0);
        check("F_rx_cleared", 64'(rx_packets), 64'd0);
        add_packet(0, 20, 0);
        run_queues(100, 50);
        check("F_rx_first", 64'(rx_packets), 64'd1);
        check("F_err_after", 64'(error), 64'd0);

        // Randomized packets against the model.
        repeat (25) begin
            int size  = $urandom_range(1, 40);
            int count = $urandom_range(1, 4);
            do_start(size, count, 2'($urandom));
            for (int l = 0; l < NCH; l++) begin
                int np = count + $urandom_range(0, 1);
                for (int p = 0; p < np; p++) begin
                    add_packet(l, size, ($urandom_range(99) < 60) ? 0 : $urandom_range(1, 5));
                end
            end
            run_queues($urandom_range(40, 100), 2000);
        end

        // Throttled instance: TVALID held high for 1000 cycles.
        t_packet_size  = 16'd8;
        t_packet_count = 16'hFFFF;
        t_tkeep = '1;
        t_tlast = '1;
        t_start = 1'b1;
        @(posedge clk);
        #1;
        t_start  = 1'b0;
        t_tvalid = '1;
        diff = 0;
        lfsr_bad = 0;
        for (int l = 0; l < NCH; l++) hi[l] = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            t_tdata = {$urandom, $urandom, $urandom, $urandom};
            for (int l = 0; l < NCH; l++) begin
                if (t_tready[l]) hi[l]++;
                if (t_tready[l] !== (m_lfsr[l][0] | m_lfsr[l][1])) lfsr_bad++;
            end
            if (t_tready[0] != t_tready[1]) diff++;
            @(posedge clk);
        end
        #1;
        t_tvalid = '0;
        @(negedge clk);
        for (int l = 0; l < NCH; l++) begin
            check("thr_duty_70_80", 64'(hi[l] >= 700 && hi[l] <= 800), 64'd1);
            check("thr_accepted", 64'(t_rx_packets[l*16 +: 16]), 64'(hi[l]));
        end
        check("thr_lfsr_seq", 64'(lfsr_bad), 64'd0);
        check("thr_lanes_differ", 64'(diff > 0), 64'd1);
        check("thr_err", 64'(t_error), 64'd0);

        // Asynchronous reset in the middle of a run.
        do_start(20, 3, '0);
        add_packet(0, 20, 0);
        add_packet(1, 20, 0);
        run_queues(100, 50);
        check("G_rx_pre", 64'(rx_packets), {32'd0, 16'd1, 16'd1});
        #2;
        resetn = 1'b0;
        #1;
        check("G_rst_tready", 64'(tready), 64'd0);
        check("G_rst_done", 64'(done), 64'd0);
        check("G_rst_err", 64'(error), 64'd0);
        check("G_rst_rx", 64'(rx_packets), 64'd0);
        check("G_rst_thr_rx", 64'(t_rx_packets), 64'd0);
        check("G_rst_thr_tready", 64'(t_tready), 64'd0);
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/axis_packet_checker.md
# axis_packet_checker

Multi-channel AXI-Stream sink that accepts packets on NCH independent receive lanes, counts them against a programmed packet count, and checks every packet's length and TKEEP against a programmed packet size. Each lane can run at full rate or with pseudo-random backpressure, and reports sticky done/error status. It sits at the end of the AXI FIFO datapath as the consumer for loopback and throughput tests.

## Interface
- DW, 512, data width per lane in bits; DW/8 must be a power of two
- NCH, 2, number of receive lanes
- THROTTLE, 0, 0 = TREADY held high while running; 1 = LFSR-throttled TREADY
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  single clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: clear all lane counters/status and arm all lanes
- packet_count  in  16  packets expected per lane, sampled on start
- packet_size  in  16  bytes per packet, sampled on start
- s_axis_tdata  in  NCH*DW  lane i at [i*DW +: DW]
- s_axis_tkeep  in  NCH*DW/8  per-lane keep
- s_axis_tlast  in  NCH  per-lane last
- s_axis_tvalid  in  NCH  per-lane valid
- s_axis_tready  out  NCH  per-lane ready
- done  out  NCH  lane received packet_count packets
- error  out  NCH*3  per lane: bit0 length, bit1 keep, bit2 overrun
- rx_packets  out  NCH*16  per-lane packet counter

## Operation
- Per-lane states:
  - IDLE: reset state, tready = 0.
  - RUN: tready = 1, or the LFSR gate when THROTTLE = 1.
  - DONE: tready = 1 and done = 1.
- Transitions:
  - IDLE→RUN on start.
  - RUN→DONE on the TLAST handshake that makes rx_packets == packet_count.
  - Any state→RUN on start.
  - start with packet_count == 0 or packet_size == 0: go straight to DONE, no errors.
- start clears beat counter, rx_packets and error in every state. start overrides a handshake in the same cycle; that beat is discarded.
- Handshake = tvalid & tready. TDATA is ignored.
- BPB = DW/8. Expected beats: beats_exp = (packet_size + BPB − 1) / BPB, computed in 17 bits.
- Expected last-beat keep:
  - rem = packet_size mod BPB.
  - keep_last = all ones if rem == 0, else (1<<rem) − 1.
- Beat counter: 16 bits, saturates at 0xFFFF, reset to 0 after each TLAST beat.
- Length error (bit0): set when a TLAST beat arrives with beat index ≠ beats_exp − 1, or when a non-TLAST beat arrives at index ≥ beats_exp − 1.
  - Set at most once per packet. The packet still ends only on TLAST.
- Keep error (bit1): set when a non-TLAST beat has keep ≠ all ones, or a TLAST beat has keep ≠ keep_last.
- Overrun (bit2): set by any handshake while in DONE. Beats are still accepted; rx_packets does not increment.
- Error bits are sticky until start or reset. Errors do not stop reception.
- rx_packets increments on every RUN TLAST handshake and wraps at 16 bits.
- Throttle LFSR, per lane:
  - 16-bit Fibonacci, x^16+x^14+x^13+x^11+1.
  - Reset seed = lane index + 1; never zero.
  - Advances every cycle in all states.
  - In RUN with THROTTLE = 1, tready = lfsr[0] | lfsr[1] (75% duty).

## Timing
- Reset values:
  - tready = 0, done = 0, error = 0, rx_packets = 0, state IDLE.
  - LFSR = lane index + 1.
- tready is a function of registered state/LFSR only, with no combinational path from tvalid.
- First beat can be accepted the cycle after start.
- rx_packets updates, and done/error assert, one clock after the causing handshake.
- The final TLAST handshake and DONE entry share that edge. A beat arriving the next cycle is overrun.
- Lanes are fully independent. Simultaneous handshakes on all lanes are all processed in the same cycle.
- packet_count/packet_size changes after start have no effect until the next start.

## Structure
- Package axis_chk_pkg:
  - lane state enum (IDLE, RUN, DONE);
  - error bit indices ERR_LEN = 0, ERR_KEEP = 1, ERR_OVR = 2;
  - LFSR taps constant.
- Sub-module axis_chk_lane: one lane with FSM, counters, keep/length checks and LFSR. Instantiated NCH times in a generate loop, with lane index passed as the seed parameter.
- Top level: only slices buses and fans out start/packet_count/packet_size.

## Test plan
- DW = 64, NCH = 2, THROTTLE = 0, size 20, count 3; three clean 3-beat packets with last keep 0x0F → done = 0b11 after the third TLAST, rx_packets = 3, error = 0.
- Lane 0 sends 2-beat TLAST packet with size 20 → error[0] = 0b001, rx_packets increments, lane 1 unaffected.
- Last beat keep 0xFF with size 20 (expects 0x0F) → keep bit set. Mid-packet keep 0x7F → keep bit set.
- After done, one extra beat → overrun bit set, tready stays 1, rx_packets unchanged.
- THROTTLE = 1, tvalid held high, 1000 cycles → tready duty 70–80%. Beats accepted equal the count of tready-high cycles. Lane 0 and lane 1 patterns differ.
- start mid-packet (beat 2 of 3) with an error already set → counters and errors clear. Next clean packet counted as packet 1. resetn low mid-run returns all outputs to reset values asynchronously.
